// File: rtl/gpio_btn_reader.sv
// Push-button front end for the KCU105 user GPIO: per-button synchroniser, debounce FSM,
// press/release/long-press pulses, and a saturating speed index for the LED rate select.
module gpio_btn_reader #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 3_000_000,
    parameter int LONG_CYCLES     = 300_000_000,
    parameter int UP_IDX          = 0,
    parameter int DOWN_IDX        = 2,
    parameter int CLR_IDX         = 4
) (
    input  logic             clk_300_i,
    input  logic             rst_i,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] long_press_o,
    output logic [2:0]       speed_o
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int HCNT_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_SAT  = HCNT_W'(LONG_CYCLES);
    localparam logic [HCNT_W-1:0] HCNT_FIRE = HCNT_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } btn_state_e;

    logic [N_BTN-1:0] sync_s1;
    logic [N_BTN-1:0] sync_s2;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_300_i) begin
        if (rst_i) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= btn_i;
            sync_s2 <= sync_s1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_state_e        state_q, state_d;
        logic [DCNT_W-1:0] dcnt_q, dcnt_d;
        logic [HCNT_W-1:0] hcnt_q, hcnt_d;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic              release_q, release_d;
        logic              long_q, long_d;

        always_ff @(posedge clk_300_i) begin
            if (rst_i) begin
                state_q   <= RELEASED;
                dcnt_q    <= '0;
                hcnt_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                dcnt_q    <= dcnt_d;
                hcnt_q    <= hcnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end

        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        always_comb begin
            state_d   = state_q;
            dcnt_d    = dcnt_q;
            hcnt_d    = hcnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;
            case (state_q)
                RELEASED: begin
                    if (sync_s2[g]) begin
                        state_d = DEB_PRESS;
                        dcnt_d  = '0;
                    end
                end
                DEB_PRESS: begin
                    if (!sync_s2[g]) begin
                        state_d = RELEASED;
                    end else if (dcnt_q == DCNT_LAST) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        hcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!sync_s2[g]) begin
                        state_d = DEB_RELEASE;
                        dcnt_d  = '0;
                    end else if (hcnt_q != HCNT_SAT) begin
                        // Saturating at LONG_CYCLES is what makes the long press one-shot.
                        hcnt_d = hcnt_q + 1'b1;
                        long_d = (hcnt_q == HCNT_FIRE);
                    end
                end
                DEB_RELEASE: begin
                    if (sync_s2[g]) begin
                        state_d = PRESSED;
                    end else if (dcnt_q == DCNT_LAST) begin
                        state_d   = RELEASED;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                default: state_d = RELEASED;
            endcase
        end

        assign btn_level_o[g]  = level_q;
        assign press_o[g]      = press_q;
        assign release_o[g]    = release_q;
        assign long_press_o[g] = long_q;
    end

    // Speed follows the registered pulses, so it moves one cycle after the event.
    always_ff @(posedge clk_300_i) begin
        if (rst_i) begin
            speed_o <= '0;
        end else if (long_press_o[CLR_IDX]) begin
            speed_o <= '0;
        end else if (press_o[UP_IDX] && press_o[DOWN_IDX]) begin
            speed_o <= speed_o;
        end else if (press_o[UP_IDX]) begin
            if (speed_o != 3'd7) speed_o <= speed_o + 3'd1;
        end else if (press_o[DOWN_IDX]) begin
            if (speed_o != 3'd0) speed_o <= speed_o - 3'd1;
        end
    end

endmodule

// File: tb/tb_gpio_btn_reader.sv
// Bench for gpio_btn_reader: directed scenarios plus random button activity,
// compared each cycle against a run-length behavioural model of the debouncer.
module tb_gpio_btn_reader;

    localparam int N    = 5;
    localparam int D    = 4;
    localparam int L    = 20;
    localparam int UP   = 0;
    localparam int DOWN = 2;
    localparam int CLR  = 4;

    logic         clk_300_i = 1'b0;
    logic         rst_i;
    logic [N-1:0] btn_i;
    logic [N-1:0] btn_level_o;
    logic [N-1:0] press_o;
    logic [N-1:0] release_o;
    logic [N-1:0] long_press_o;
    logic [2:0]   speed_o;

    always #5 clk_300_i = ~clk_300_i;

    gpio_btn_reader #(
        .N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L),
        .UP_IDX(UP), .DOWN_IDX(DOWN), .CLR_IDX(CLR)
    ) dut (
        .clk_300_i(clk_300_i),
        .rst_i(rst_i),
        .btn_i(btn_i),
        .btn_level_o(btn_level_o),
        .press_o(press_o),
        .release_o(release_o),
        .long_press_o(long_press_o),
        .speed_o(speed_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: input delayed two cycles; a level flips once the delayed input has
    // disagreed with it for D+1 consecutive cycles; held time counts agreeing cycles.
    logic [N-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_long;
    int m_run [N];
    int m_hold[N];
    int m_speed;

    int press_cnt[N], rel_cnt[N], long_cnt[N];
    int last_press[N], last_rel[N];

    task automatic model_step();
        if (rst_i) begin
            m_s1 = '0; m_s2 = '0; m_level = '0;
            m_press = '0; m_rel = '0; m_long = '0;
            m_speed = 0;
            for (int b = 0; b < N; b++) begin
                m_run[b] = 0; m_hold[b] = 0;
            end
        end else begin
            if (m_long[CLR])                     m_speed = 0;
            else if (m_press[UP] && m_press[DOWN]) m_speed = m_speed;
            else if (m_press[UP])                m_speed = (m_speed < 7) ? m_speed + 1 : 7;
            else if (m_press[DOWN])              m_speed = (m_speed > 0) ? m_speed - 1 : 0;
            for (int b = 0; b < N; b++) begin
                logic s;
                s = m_s2[b];
                m_press[b] = 1'b0; m_rel[b] = 1'b0; m_long[b] = 1'b0;
                if (s != m_level[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D + 1) begin
                        m_level[b] = s;
                        m_run[b]   = 0;
                        if (s) begin
                            m_press[b] = 1'b1;
                            m_hold[b]  = 0;
                        end else begin
                            m_rel[b] = 1'b1;
                        end
                    end
                end else begin
                    if (m_level[b] && m_run[b] == 0 && m_hold[b] < L) begin
                        if (m_hold[b] == L - 1) m_long[b] = 1'b1;
                        m_hold[b]++;
                    end
                    m_run[b] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_i;
        end
    endtask

    task automatic compare();
        check("level", 32'(btn_level_o), 32'(m_level));
        check("press", 32'(press_o), 32'(m_press));
        check("release", 32'(release_o), 32'(m_rel));
        check("long", 32'(long_press_o), 32'(m_long));
        check("speed", 32'(speed_o), 32'(m_speed));
        for (int b = 0; b < N; b++) begin
            if (press_o[b] === 1'b1)      begin press_cnt[b]++; last_press[b] = cyc; end
            if (release_o[b] === 1'b1)    begin rel_cnt[b]++;   last_rel[b]   = cyc; end
            if (long_press_o[b] === 1'b1) long_cnt[b]++;
        end
    endtask

    task automatic tick();
        @(posedge clk_300_i);
        cyc++;
        model_step();
        @(negedge clk_300_i);
        compare();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic press_btn(input int b, input int hold, input int gap);
        btn_i[b] = 1'b1;
        run(hold);
        btn_i[b] = 1'b0;
        run(gap);
    endtask

    int rise, fall, p0, l0, r0, rst_edge;

    initial begin
        for (int b = 0; b < N; b++) begin
            press_cnt[b] = 0; rel_cnt[b] = 0; long_cnt[b] = 0;
            last_press[b] = -1000; last_rel[b] = -1000;
        end
        rst_i = 1'b1;
        btn_i = '0;
        run(3);
        check("rst_level", 32'(btn_level_o), 0);
        check("rst_speed", 32'(speed_o), 0);
        rst_i = 1'b0;
        run(2);

        // Clean press of UP held 30 cycles.
        p0 = press_cnt[0]; l0 = long_cnt[0];
        rise = cyc + 1;
        btn_i[0] = 1'b1;
        run(30);
        fall = cyc + 1;
        btn_i[0] = 1'b0;
        run(12);
        check("s1_press_lat", 32'(last_press[0] - rise), 6);
        check("s1_rel_lat", 32'(last_rel[0] - fall), 6);
        check("s1_press_cnt", 32'(press_cnt[0] - p0), 1);
        check("s1_long_cnt", 32'(long_cnt[0] - l0), 1);
        check("s1_speed", 32'(speed_o), 1);

        // Short glitch on DOWN.
        p0 = press_cnt[2];
        btn_i[2] = 1'b1;
        run(3);
        btn_i[2] = 1'b0;
        run(10);
        check("s2_press_cnt", 32'(press_cnt[2] - p0), 0);
        check("s2_level", 32'(btn_level_o[2]), 0);
        check("s2_speed", 32'(speed_o), 1);

        // Brief drop during a hold on btn 1.
        p0 = press_cnt[1]; r0 = rel_cnt[1];
        btn_i[1] = 1'b1; run(15);
        btn_i[1] = 1'b0; run(2);
        btn_i[1] = 1'b1; run(10);
        check("s3_mid_rel", 32'(rel_cnt[1] - r0), 0);
        btn_i[1] = 1'b0; run(12);
        check("s3_press_cnt", 32'(press_cnt[1] - p0), 1);
        check("s3_rel_cnt", 32'(rel_cnt[1] - r0), 1);

        // Saturation in both directions.
        for (int i = 0; i < 9; i++) begin
            press_btn(UP, 10, 8);
            check("s4_up", 32'(speed_o), (1 + i + 1 > 7) ? 7 : 1 + i + 1);
        end
        for (int i = 0; i < 9; i++) begin
            press_btn(DOWN, 10, 8);
            check("s4_down", 32'(speed_o), (7 - i - 1 < 0) ? 0 : 7 - i - 1);
        end

        // Simultaneous UP/DOWN, then long press on CLR.
        repeat (5) press_btn(UP, 10, 8);
        check("s5_speed5", 32'(speed_o), 5);
        btn_i[UP] = 1'b1; btn_i[DOWN] = 1'b1;
        run(10);
        btn_i[UP] = 1'b0; btn_i[DOWN] = 1'b0;
        run(10);
        check("s5_both", 32'(speed_o), 5);
        press_btn(CLR, 35, 10);
        check("s5_clr", 32'(speed_o), 0);

        // Reset while btn 3 is held.
        btn_i[3] = 1'b1;
        run(12);
        check("s6_held_level", 32'(btn_level_o[3]), 1);
        r0 = rel_cnt[3];
        rst_i = 1'b1;
        tick();
        rst_edge = cyc;
        check("s6_rst_level", 32'(btn_level_o), 0);
        rst_i = 1'b0;
        run(15);
        check("s6_no_release", 32'(rel_cnt[3] - r0), 0);
        check("s6_press_lat", 32'(last_press[3] - rst_edge), 7);
        btn_i[3] = 1'b0;
        run(12);

        // Random activity on all buttons with occasional resets.
        repeat (3000) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 99) < 8) btn_i[b] = ~btn_i[b];
            rst_i = ($urandom_range(0, 999) < 3);
            tick();
        end
        rst_i = 1'b0;
        btn_i = '0;
        run(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
